// File: rtl/mult_accumulator_8b.sv
// Multiply-accumulate back end: sums a batch of num_terms unsigned 8-bit products
// taken over a valid/ready handshake, pulses done, holds result and sticky overflow.
module mult_accumulator_8b #(
    parameter int ACC_WIDTH = 12,
    parameter int NT_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NT_WIDTH-1:0]  num_terms,
    input  logic [7:0]           product,
    input  logic                 prod_valid,
    output logic                 prod_ready,
    output logic                 busy,
    output logic                 done,
    output logic [ACC_WIDTH-1:0] acc_result,
    output logic                 overflow
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t               state, state_nxt;
    logic [NT_WIDTH-1:0]  count, terms;
    logic                 hs;
    logic                 last;
    logic [ACC_WIDTH:0]   sum;

    // Handshake qualifiers decode purely from state; no path from prod_valid to prod_ready.
    assign prod_ready = (state == ACCUM);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    assign hs   = prod_valid & prod_ready;
    assign last = (count == terms - NT_WIDTH'(1));
    assign sum  = {1'b0, acc_result} + {{(ACC_WIDTH-7){1'b0}}, product};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (num_terms == '0) ? DONE : ACCUM;
            ACCUM:   if (hs && last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_result <= '0;
            count      <= '0;
            terms      <= '0;
            overflow   <= 1'b0;
        end else if (state == IDLE && start) begin
            acc_result <= '0;
            count      <= '0;
            terms      <= num_terms;
            overflow   <= 1'b0;
        end else if (hs) begin
            // Carry out of the ACC_WIDTH-bit add marks wrap-around until the next batch.
            acc_result <= sum[ACC_WIDTH-1:0];
            count      <= count + NT_WIDTH'(1);
            if (sum[ACC_WIDTH]) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mult_accumulator_8b.sv
// Randomized scoreboard bench for mult_accumulator_8b: batch totals computed from
// plain integer sums are queued at start and checked by a monitor on each done pulse.
module tb_mult_accumulator_8b;

    localparam int ACC_WIDTH = 12;
    localparam int NT_WIDTH  = 5;
    localparam int MODV      = 1 << ACC_WIDTH;

    logic                 clk, rst_n, start, prod_valid;
    logic [NT_WIDTH-1:0]  num_terms;
    logic [7:0]           product;
    logic                 prod_ready, busy, done, overflow;
    logic [ACC_WIDTH-1:0] acc_result;

    typedef struct {
        int acc;
        int ovf;
    } exp_t;

    exp_t exp_q[$];
    int   prods[$];
    int   gaps[$];
    int   compared   = 0;
    int   mismatched = 0;

    bit   prev_event = 0;
    bit   held_chk   = 0;
    exp_t held;

    mult_accumulator_8b #(.ACC_WIDTH(ACC_WIDTH), .NT_WIDTH(NT_WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_terms(num_terms),
        .product(product), .prod_valid(prod_valid), .prod_ready(prod_ready),
        .busy(busy), .done(done), .acc_result(acc_result), .overflow(overflow)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Monitor: pops one expectation per done pulse and checks latency and hold behaviour.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_event = 0;
            held_chk   = 0;
        end else begin
            if (held_chk) begin
                check("done_pulse", int'(done), 0);
                check("acc_held", int'(acc_result), held.acc);
                check("ovf_held", int'(overflow), held.ovf);
                held_chk = 0;
            end
            if (done === 1'b1) begin
                check("done_latency", int'(prev_event), 1);
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_done: got done=1 expected no pending batch at %0t", $time);
                end else begin
                    held = exp_q.pop_front();
                    check("acc_result", int'(acc_result), held.acc);
                    check("overflow", int'(overflow), held.ovf);
                    held_chk = 1;
                end
            end
            prev_event = (prod_valid && prod_ready) ||
                         (!busy && start && num_terms == '0);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_ready"}, int'(prod_ready), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_acc"}, int'(acc_result), 0);
        check({tag, "_ovf"}, int'(overflow), 0);
    endtask

    // Runs one batch from prods/gaps; abort_at>=0 pulses reset after that many handshakes.
    task automatic run_batch(input int abort_at, input bit poke_start);
        int n = prods.size();
        int total = 0;
        int b;
        foreach (prods[i]) total += prods[i];
        if (abort_at < 0) exp_q.push_back('{acc: total % MODV, ovf: (total >= MODV) ? 1 : 0});

        @(posedge clk); #1;
        start = 1;
        num_terms = NT_WIDTH'(n);
        @(posedge clk); #1;
        start = 0;
        num_terms = NT_WIDTH'($urandom);

        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                rst_n = 0;
                #1;
                check_all_zero("abort");
                @(posedge clk); #1;
                rst_n = 1;
                prod_valid = 0;
                return;
            end
            for (int g = 0; g < gaps[i]; g++) begin
                prod_valid = 0;
                product = 8'($urandom);
                if (poke_start) start = 1;
                @(posedge clk); #1;
                start = 0;
            end
            prod_valid = 1;
            product = 8'(prods[i]);
            b = 0;
            @(negedge clk);
            while (!prod_ready) begin
                if (++b > 50) begin
                    timeout("prod_ready_wait");
                    break;
                end
                @(negedge clk);
            end
            @(posedge clk); #1;
            prod_valid = 0;
            product = 8'($urandom);
        end

        b = 0;
        @(negedge clk);
        while (busy) begin
            if (n == 0) check("zero_batch_ready", int'(prod_ready), 0);
            if (++b > 10) begin
                timeout("batch_end_wait");
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic set_batch(input int n, input int val, input int gap);
        prods.delete();
        gaps.delete();
        for (int i = 0; i < n; i++) begin
            prods.push_back(val);
            gaps.push_back(gap);
        end
    endtask

    initial begin
        rst_n = 1;
        start = 0;
        num_terms = '0;
        product = '0;
        prod_valid = 0;

        // Asynchronous reset asserted between edges.
        #12 rst_n = 0;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1;

        set_batch(4, 225, 0);
        run_batch(-1, 0);                       // 900, no overflow

        set_batch(19, 225, 0);
        run_batch(-1, 0);                       // 4275 mod 4096 = 179, overflow
        set_batch(1, 6, 0);
        run_batch(-1, 0);                       // overflow cleared

        set_batch(0, 0, 0);
        run_batch(-1, 0);                       // empty batch

        prods = '{10, 20, 30};
        gaps  = '{0, 2, 5};
        run_batch(-1, 1);                       // gaps with start pokes in ACCUM

        set_batch(5, 77, 0);
        run_batch(2, 0);                        // reset after 2 handshakes
        prods = '{100, 50};
        gaps  = '{0, 0};
        run_batch(-1, 0);

        set_batch(31, 255, 0);
        run_batch(-1, 0);                       // largest batch, max products

        for (int t = 0; t < 40; t++) begin
            int n = $urandom_range(0, 31);
            int gmax = $urandom_range(0, 3);
            prods.delete();
            gaps.delete();
            for (int i = 0; i < n; i++) begin
                prods.push_back($urandom_range(0, 255));
                gaps.push_back($urandom_range(0, gmax));
            end
            run_batch(-1, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
